a2d_spi_resp: RTL and testbench

Synthesizable SPI responder that emulates the 8-channel, 12-bit A2D converter on the DE0 board: the far end of the A2D SPI link driven by the eBike's A2D interface (`A2D_SS_n`/`A2D_SCLK`/`A2D_MOSI` in, `A2D_MISO` out). Each 16-bit frame returns the conversion result for the channel requested in the *previous* frame. Four channels are sourced from 12-bit value ports set by the bench or a plant model. The block lets the full-chip bench and FPGA loopback builds run without the physical converter.

---
 rtl/a2d_pkg.sv | 17 +
 rtl/spi_edge_sync.sv | 25 ++
 rtl/a2d_spi_resp.sv | 140 ++++++++++++++
 tb/tb_a2d_spi_resp.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants and types for the A2D SPI responder: frame length,
// channel numbers and the frame state machine encoding.
package a2d_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [2:0] CH_BATT   = 3'd0;
    localparam logic [2:0] CH_CURR   = 3'd1;
    localparam logic [2:0] CH_BRAKE  = 3'd3;
    localparam logic [2:0] CH_TORQUE = 3'd4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchronizer for an asynchronous pin, producing one-clk
// rise/fall strobes from the two metastability-settled stages.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sync;

    // Resetting to 0 means a pin already low at reset release never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], din};
        end
    end

    assign rise = sync[1] & ~sync[2];
    assign fall = ~sync[1] & sync[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating the DE0 8-channel 12-bit A2D: each 16-bit frame
// returns the held result for the channel commanded in the previous frame.
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter logic [2:0] RST_CH = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] brake,
    input  logic [11:0] torque,
    output logic [7:0]  frm_cnt,
    output logic        frm_err
);

    localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);

    state_t      state;
    state_t      state_nxt;
    logic        ss_rise;
    logic        ss_fall;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_meta;
    logic        mosi_s;
    logic [15:0] tx_shft;
    // Only the channel field [13:11] of the command is ever consumed, so the
    // two bits above it are not kept.
    logic [13:0] rx_shft;
    logic [4:0]  bit_cnt;
    logic [11:0] result;
    logic [2:0]  chnl;
    logic [2:0]  chnl_nxt;
    logic [11:0] sample;
    logic        frame_ok;

    spi_edge_sync u_ss_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (SS_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_edge_sync u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= MOSI;
            mosi_s    <= mosi_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign frame_ok = (state == ACTIVE) && ss_rise && (bit_cnt == FRAME_LEN);

    // Sample-and-hold: the channel is decoded and its value captured in the same clk.
    always_comb begin
        chnl_nxt = chnl;
        if (frame_ok) chnl_nxt = rx_shft[13:11];
        sample = 12'h000;
        case (chnl_nxt)
            CH_BATT:   sample = batt;
            CH_CURR:   sample = curr;
            CH_BRAKE:  sample = brake;
            CH_TORQUE: sample = torque;
            default:   sample = 12'h000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= '0;
            rx_shft <= '0;
            bit_cnt <= '0;
            result  <= '0;
            chnl    <= RST_CH;
            frm_cnt <= '0;
            frm_err <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall) begin
                    tx_shft <= {4'h0, result};
                    rx_shft <= '0;
                    bit_cnt <= '0;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shft <= {rx_shft[12:0], mosi_s};
                    if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                end
                if (sclk_fall) tx_shft <= {tx_shft[14:0], 1'b0};
                if (ss_rise) begin
                    if (frame_ok) begin
                        chnl    <= chnl_nxt;
                        result  <= sample;
                        frm_cnt <= frm_cnt + 8'd1;
                    end else begin
                        frm_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign MISO = tx_shft[15];

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: directed frames for the
// previous-frame pipeline, hold, error frames and reset, then random frames.
module tb_a2d_spi_resp;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] brake;
    logic [11:0] torque;
    logic [7:0]  frm_cnt;
    logic        frm_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    a2d_spi_resp #(.RST_CH(3'd0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .batt   (batt),
        .curr   (curr),
        .brake  (brake),
        .torque (torque),
        .frm_cnt(frm_cnt),
        .frm_err(frm_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frm_err === 1'b1) err_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 initiator: MOSI set while SCLK low, MISO captured just before each rise.
    task automatic send_bits(input logic [15:0] cmd, input int n, output logic [15:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            wait_clks(HALF);
            if (i < 16) word[15-i] = MISO;
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        wait_clks(HALF);
    endtask

    task automatic frame(input logic [15:0] cmd, input int n, output logic [15:0] word);
        SS_n = 1'b0;
        wait_clks(HALF);
        send_bits(cmd, n, word);
        SS_n = 1'b1;
        wait_clks(HALF + 2);
    endtask

    function automatic logic [11:0] model_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return batt;
            3'd1:    return curr;
            3'd3:    return brake;
            3'd4:    return torque;
            default: return 12'h000;
        endcase
    endfunction

    initial begin
        logic [15:0] w;
        logic [15:0] cmd;
        logic [11:0] m_result;
        int          e0;

        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        batt = 12'h000; curr = 12'h000; brake = 12'h000; torque = 12'h000;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(4);

        check("reset_miso", MISO, 0);
        check("reset_frm_cnt", frm_cnt, 0);
        check("reset_frm_err", frm_err, 0);
        check("reset_chnl", dut.chnl, 0);

        curr = 12'hABC;
        frame(16'h0800, 16, w);
        check("first_frame_word", w, 16'h0000);
        check("first_frame_cnt", frm_cnt, 1);
        check("first_frame_chnl", dut.chnl, 1);

        torque = 12'h123;
        frame(16'h2000, 16, w);
        check("curr_word", w, 16'h0ABC);
        check("cnt_2", frm_cnt, 2);

        brake = 12'h7FF;
        frame(16'h1800, 16, w);
        check("torque_word", w, 16'h0123);
        brake = 12'h900;
        frame(16'h3000, 16, w);
        check("brake_held_word", w, 16'h07FF);
        frame(16'h1800, 16, w);
        check("ch6_word", w, 16'h0000);
        check("cnt_5", frm_cnt, 5);

        e0 = err_pulses;
        frame(16'h2000, 15, w);
        check("short_err_pulse", err_pulses, e0 + 1);
        check("short_cnt_hold", frm_cnt, 5);
        frame(16'h0800, 0, w);
        check("empty_err_pulse", err_pulses, e0 + 2);
        frame(16'h2000, 17, w);
        check("long_err_pulse", err_pulses, e0 + 3);
        check("err_cnt_hold", frm_cnt, 5);
        check("err_chnl_hold", dut.chnl, 3);

        curr = 12'hFFF;
        frame(16'h0800, 16, w);
        check("after_err_word", w, 16'h0900);
        check("cnt_6", frm_cnt, 6);

        // Abandon a frame halfway: held result FFF puts a 1 on MISO after 8 shifts.
        e0 = err_pulses;
        SS_n = 1'b0;
        wait_clks(HALF);
        send_bits(16'h0000, 8, w);
        check("pre_reset_miso", MISO, 1);
        rst_n = 1'b0;
        wait_clks(2);
        check("in_reset_miso", MISO, 0);
        rst_n = 1'b1;
        wait_clks(HALF);
        SS_n = 1'b1;
        wait_clks(HALF + 2);
        check("post_reset_no_err", err_pulses, e0);
        check("post_reset_cnt", frm_cnt, 0);
        check("post_reset_chnl", dut.chnl, 0);

        batt = 12'h5A5;
        frame(16'h0000, 16, w);
        check("post_reset_word", w, 16'h0000);
        m_result = batt;

        for (int k = 0; k < 255; k++) begin
            batt   = 12'($urandom);
            curr   = 12'($urandom);
            brake  = 12'($urandom);
            torque = 12'($urandom);
            cmd    = 16'($urandom);
            frame(cmd, 16, w);
            check($sformatf("rand_word_%0d", k), w, {4'h0, m_result});
            m_result = model_val(cmd[13:11]);
        end
        check("wrap_cnt", frm_cnt, 0);
        check("rand_no_err", err_pulses, e0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
